// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: one N-bit carry-propagate slice reused
// over WORDS cycles, LSB chunk first, with valid/ready on both sides.

module wide_add_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module wide_add_sequencer #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WORDS-1:0][N-1:0] a_reg, b_reg, sum_reg;
  logic [IW-1:0]           idx;
  logic                    carry, cout_r, ovf_r;

  logic [N-1:0] sl_a, sl_b, sl_s;
  logic         sl_c, last;

  assign last = (idx == IW'(WORDS-1));

  // Chunk select is an explicit mux so the index width never has to match the array depth.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        sl_a = a_reg[i];
        sl_b = b_reg[i];
      end
    end
  end

  wide_add_slice #(.N(N)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction is a + ~b + 1: invert b on capture and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_reg <= a;
          b_reg <= sub ? ~b : b;
          carry <= sub;
          idx   <= '0;
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++)
            if (idx == IW'(i)) sum_reg[i] <= sl_s;
          carry <= sl_c;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout_r <= sl_c;
            ovf_r  <= (sl_a[N-1] == sl_b[N-1]) && (sl_s[N-1] != sl_a[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and randomized bench for wide_add_sequencer: N=16/WORDS=4 main
// instance plus N=8/WORDS=3 and N=16/WORDS=1 regression instances.

module tb_wide_add_sequencer;
  logic clk;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, N=16 WORDS=4
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, cout, overflow, busy;
  logic [63:0] a, b, sum;

  wide_add_sequencer #(.N(16), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow),
    .busy(busy)
  );

  // N=8 WORDS=3
  logic        r3_valid, r3_ready, r3_sub, r3_ovalid, r3_oready, r3_cout, r3_ovf, r3_busy;
  logic [23:0] r3_a, r3_b, r3_sum;

  wide_add_sequencer #(.N(8), .WORDS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(r3_valid), .in_ready(r3_ready), .a(r3_a), .b(r3_b),
    .sub(r3_sub), .out_valid(r3_ovalid), .out_ready(r3_oready), .sum(r3_sum), .cout(r3_cout),
    .overflow(r3_ovf), .busy(r3_busy)
  );

  // N=16 WORDS=1
  logic        r1_valid, r1_ready, r1_sub, r1_ovalid, r1_oready, r1_cout, r1_ovf, r1_busy;
  logic [15:0] r1_a, r1_b, r1_sum;

  wide_add_sequencer #(.N(16), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(r1_valid), .in_ready(r1_ready), .a(r1_a), .b(r1_b),
    .sub(r1_sub), .out_valid(r1_ovalid), .out_ready(r1_oready), .sum(r1_sum), .cout(r1_cout),
    .overflow(r1_ovf), .busy(r1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the main instance; lat counts cycles from the
  // handshake cycle (cycle 0) to the first cycle with out_valid high.
  task automatic op_m(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                      input logic accept, output logic [63:0] rs, output logic rc,
                      output logic ro, output int lat);
    int guard = 0;
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    rs = sum; rc = cout; ro = overflow;
    if (accept) begin
      out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready_during_rst got=%b exp=0", in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      failures++; $display("FAIL reset_state got rdy/busy/vld=%b exp=100", {in_ready, busy, out_valid});
    end
    checks++;
    if ({sum, cout, overflow} !== 66'd0) begin
      failures++; $display("FAIL reset_outputs got sum=%h c=%b v=%b exp=0", sum, cout, overflow);
    end
  endtask

  task automatic test_add_carry();
    logic [63:0] rs; logic rc, ro; int lat;
    op_m(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++;
    if ({rs, rc, ro} !== {64'h0001_0000_0000_0000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_carry got sum=%h c=%b v=%b exp sum=0001000000000000 c=0 v=0", rs, rc, ro);
    end
    checks++;
    if (lat != 5) begin
      failures++; $display("FAIL add_latency got=%0d exp=5", lat);
    end
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL after_accept got vld/rdy/busy=%b exp=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_sub();
    logic [63:0] rs; logic rc, ro; int lat;
    op_m(64'd0, 64'd1, 1'b1, 1'b1, rs, rc, ro, lat);
    checks++;
    if ({rs, rc, ro} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub_0_1 got sum=%h c=%b v=%b exp sum=ffffffffffffffff c=0 v=0", rs, rc, ro);
    end
    op_m(64'd5, 64'd3, 1'b1, 1'b1, rs, rc, ro, lat);
    checks++;
    if ({rs, rc, ro} !== {64'd2, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_5_3 got sum=%h c=%b v=%b exp sum=2 c=1 v=0", rs, rc, ro);
    end
  endtask

  task automatic test_overflow_wrap();
    logic [63:0] rs; logic rc, ro; int lat;
    op_m(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++;
    if ({rs, rc, ro} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
      failures++; $display("FAIL ovf_pos got sum=%h c=%b v=%b exp sum=8000000000000000 c=0 v=1", rs, rc, ro);
    end
    op_m(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++;
    if ({rs, rc, ro} !== {64'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL wrap got sum=%h c=%b v=%b exp sum=0 c=1 v=0", rs, rc, ro);
    end
    // Negative - positive overflow: 0x8000.. - 1
    op_m(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, rs, rc, ro, lat);
    checks++;
    if ({rs, rc, ro} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
      failures++; $display("FAIL ovf_neg got sum=%h c=%b v=%b exp sum=7fffffffffffffff c=1 v=1", rs, rc, ro);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rs; logic rc, ro; int lat; int bad = 0;
    out_ready = 1'b0;
    op_m(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++;
    if (rs !== 64'h2345_6789_ABCD_F001 || rc !== 1'b0) begin
      failures++; $display("FAIL bp_result got sum=%h c=%b exp sum=23456789abcdf001 c=0", rs, rc);
    end
    a = 64'd100; b = 64'd200; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== rs || cout !== rc) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL bp_release got vld/rdy/busy=%b exp=010", {out_valid, in_ready, busy});
    end
    op_m(64'd100, 64'd200, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++;
    if (rs !== 64'd300 || lat != 5) begin
      failures++; $display("FAIL bp_next got sum=%h lat=%0d exp sum=12c lat=5", rs, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] rs; logic rc, ro; int lat;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; sub = 1'b0; in_valid = 1'b1;
    tick();          // handshake edge; idx 0 now in flight
    in_valid = 1'b0;
    tick();          // idx 1
    tick();          // idx 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++; $display("FAIL mid_run_reset got vld/busy/rdy=%b exp=001", {out_valid, busy, in_ready});
    end
    op_m(64'd3, 64'd4, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++;
    if (rs !== 64'd7 || rc !== 1'b0 || lat != 5) begin
      failures++; $display("FAIL post_reset_add got sum=%h c=%b lat=%0d exp sum=7 c=0 lat=5", rs, rc, lat);
    end
  endtask

  task automatic test_random_n8w3();
    logic [23:0] ta, tb, be, esum; logic ts, ec, ev; logic [24:0] full;
    int lat, guard, bad_val = 0, bad_lat = 0;
    logic acc;
    for (int n = 0; n < 1000; n++) begin
      ta = 24'($urandom); tb = 24'($urandom); ts = 1'($urandom);
      be = ts ? ~tb : tb;
      full = {1'b0, ta} + {1'b0, be} + 25'(ts);
      esum = full[23:0]; ec = full[24];
      ev = (ta[23] == be[23]) && (esum[23] != ta[23]);
      r3_a = ta; r3_b = tb; r3_sub = ts; r3_valid = 1'b1;
      guard = 0;
      while (!r3_ready && guard < 20) begin tick(); guard++; end
      tick();
      r3_valid = 1'b0;
      lat = 1;
      while (!r3_ovalid && lat < 100) begin r3_oready = 1'($urandom); tick(); lat++; end
      if (lat != 4) bad_lat++;
      if ({r3_sum, r3_cout, r3_ovf} !== {esum, ec, ev}) begin
        bad_val++;
        if (bad_val <= 5)
          $display("FAIL rand_n8w3 a=%h b=%h sub=%b got sum=%h c=%b v=%b exp sum=%h c=%b v=%b",
                   ta, tb, ts, r3_sum, r3_cout, r3_ovf, esum, ec, ev);
      end
      guard = 0;
      do begin acc = 1'($urandom); r3_oready = acc; tick(); guard++; end while (!acc && guard < 50);
      r3_oready = 1'b0;
    end
    checks++;
    if (bad_val != 0) failures++;
    checks++;
    if (bad_lat != 0) begin
      failures++; $display("FAIL rand_n8w3_latency got %0d bad ops exp 0", bad_lat);
    end
  endtask

  task automatic test_random_n16w1();
    logic [15:0] ta, tb, be, esum; logic ts, ec, ev; logic [16:0] full;
    int lat, guard, bad_val = 0, bad_lat = 0;
    logic acc;
    for (int n = 0; n < 1000; n++) begin
      ta = 16'($urandom); tb = 16'($urandom); ts = 1'($urandom);
      be = ts ? ~tb : tb;
      full = {1'b0, ta} + {1'b0, be} + 17'(ts);
      esum = full[15:0]; ec = full[16];
      ev = (ta[15] == be[15]) && (esum[15] != ta[15]);
      r1_a = ta; r1_b = tb; r1_sub = ts; r1_valid = 1'b1;
      guard = 0;
      while (!r1_ready && guard < 20) begin tick(); guard++; end
      tick();
      r1_valid = 1'b0;
      lat = 1;
      while (!r1_ovalid && lat < 100) begin r1_oready = 1'($urandom); tick(); lat++; end
      if (lat != 2) bad_lat++;
      if ({r1_sum, r1_cout, r1_ovf} !== {esum, ec, ev}) begin
        bad_val++;
        if (bad_val <= 5)
          $display("FAIL rand_n16w1 a=%h b=%h sub=%b got sum=%h c=%b v=%b exp sum=%h c=%b v=%b",
                   ta, tb, ts, r1_sum, r1_cout, r1_ovf, esum, ec, ev);
      end
      guard = 0;
      do begin acc = 1'($urandom); r1_oready = acc; tick(); guard++; end while (!acc && guard < 50);
      r1_oready = 1'b0;
    end
    checks++;
    if (bad_val != 0) failures++;
    checks++;
    if (bad_lat != 0) begin
      failures++; $display("FAIL rand_n16w1_latency got %0d bad ops exp 0", bad_lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    r3_valid = 1'b0; r3_a = '0; r3_b = '0; r3_sub = 1'b0; r3_oready = 1'b0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_sub = 1'b0; r1_oready = 1'b0;
    #1;
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow_wrap();
    test_backpressure();
    test_reset_mid_run();
    test_random_n8w3();
    test_random_n16w1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
